// File: rtl/reset_sequencer.sv
// Startup reset sequencer: debounces PLL lock, releases reset domains one at a time,
// and restarts the whole sequence on sustained lock loss or a software request.
module reset_sequencer #(
    parameter int NDOM          = 4,
    parameter int NLOCK         = 2,
    parameter int LOCK_DEBOUNCE = 1024,
    parameter int STAGE_DELAY   = 256,
    parameter int LOSS_FILTER   = 4
) (
    input  logic             rstclk,
    input  logic             extreset,
    input  logic [NLOCK-1:0] locked,
    input  logic             sw_reset,
    output logic [NDOM-1:0]  rst_out,
    output logic             ready,
    output logic [1:0]       state,
    output logic [7:0]       lock_loss_cnt
);

    // state      | meaning
    // ST_RESET   | held by extreset; leaves on the first edge after release
    // ST_WAIT    | debouncing lock_sync, all domains in reset
    // ST_RELEASE | dropping domain resets one per STAGE_DELAY cycles
    // ST_RUN     | all domains released, ready high
    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    localparam int DW = (LOCK_DEBOUNCE > 2) ? $clog2(LOCK_DEBOUNCE) : 1;
    localparam int SW = (STAGE_DELAY > 2) ? $clog2(STAGE_DELAY) : 1;
    localparam int LW = (LOSS_FILTER > 2) ? $clog2(LOSS_FILTER) : 1;
    localparam int IW = (NDOM > 1) ? $clog2(NDOM) : 1;

    // Timers are down-counters loaded with N-1; the action fires on the cycle they sit at zero.
    localparam logic [DW-1:0] DEB_LOAD   = DW'(LOCK_DEBOUNCE - 1);
    localparam logic [SW-1:0] STAGE_LOAD = SW'(STAGE_DELAY - 1);
    localparam logic [LW-1:0] LOSS_LOAD  = LW'(LOSS_FILTER - 1);
    localparam logic [IW-1:0] LAST_DOM   = IW'(NDOM - 1);

    logic [NLOCK-1:0] sync1, sync2;
    logic             lock_sync;

    state_t          state_q, state_d;
    logic [DW-1:0]   deb_cnt, deb_d;
    logic [SW-1:0]   stage_cnt, stage_d;
    logic [LW-1:0]   loss_cnt, loss_d;
    logic [IW-1:0]   dom_idx, idx_d;
    logic [NDOM-1:0] rst_q, rst_d;
    logic            ready_q, ready_d;
    logic [7:0]      llc_q, llc_d;
    logic            loss_hit;

    assign lock_sync = &sync2;

    always_ff @(posedge rstclk or posedge extreset) begin
        if (extreset) begin
            sync1     <= '0;
            sync2     <= '0;
            state_q   <= ST_RESET;
            deb_cnt   <= '0;
            stage_cnt <= '0;
            loss_cnt  <= '0;
            dom_idx   <= '0;
            rst_q     <= '1;
            ready_q   <= 1'b0;
            llc_q     <= '0;
        end else begin
            sync1     <= locked;
            sync2     <= sync1;
            state_q   <= state_d;
            deb_cnt   <= deb_d;
            stage_cnt <= stage_d;
            loss_cnt  <= loss_d;
            dom_idx   <= idx_d;
            rst_q     <= rst_d;
            ready_q   <= ready_d;
            llc_q     <= llc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        deb_d    = deb_cnt;
        stage_d  = stage_cnt;
        loss_d   = loss_cnt;
        idx_d    = dom_idx;
        rst_d    = rst_q;
        ready_d  = ready_q;
        llc_d    = llc_q;
        loss_hit = 1'b0;

        if ((state_q == ST_RELEASE || state_q == ST_RUN) && !lock_sync) begin
            if (loss_cnt == '0) loss_hit = 1'b1;
            else                loss_d   = loss_cnt - 1'b1;
        end else begin
            loss_d = LOSS_LOAD;
        end

        unique case (state_q)
            ST_RESET: begin
                state_d = ST_WAIT;
                deb_d   = DEB_LOAD;
            end
            ST_WAIT: begin
                if (!lock_sync) begin
                    deb_d = DEB_LOAD;
                end else if (deb_cnt == '0) begin
                    state_d = ST_RELEASE;
                    stage_d = STAGE_LOAD;
                    idx_d   = '0;
                end else begin
                    deb_d = deb_cnt - 1'b1;
                end
            end
            ST_RELEASE: begin
                if (stage_cnt == '0) begin
                    rst_d[dom_idx] = 1'b0;
                    stage_d        = STAGE_LOAD;
                    if (dom_idx == LAST_DOM) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                    end else begin
                        idx_d = dom_idx + 1'b1;
                    end
                end else begin
                    stage_d = stage_cnt - 1'b1;
                end
            end
            ST_RUN: ;
            default: state_d = ST_RESET;
        endcase

        // Software restart outranks lock loss, so a simultaneous loss is not counted.
        if (state_q != ST_RESET && (sw_reset || loss_hit)) begin
            state_d = ST_WAIT;
            deb_d   = DEB_LOAD;
            stage_d = STAGE_LOAD;
            loss_d  = LOSS_LOAD;
            idx_d   = '0;
            rst_d   = '1;
            ready_d = 1'b0;
            if (!sw_reset && llc_q != 8'hFF) llc_d = llc_q + 8'd1;
        end
    end

    assign rst_out       = rst_q;
    assign ready         = ready_q;
    assign state         = state_q;
    assign lock_loss_cnt = llc_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: stimulus pushes expected output changes (with their edge number)
// into a queue; a monitor pops one entry each time the sampled outputs change.
module tb_reset_sequencer;

    localparam int NDOM = 3;
    localparam int NLOCK = 2;

    logic             clk = 1'b0;
    logic             extreset = 1'b1;
    logic [NLOCK-1:0] locked = 2'b11;
    logic             sw_reset = 1'b0;
    logic [NDOM-1:0]  rst_out;
    logic             ready;
    logic [1:0]       state;
    logic [7:0]       lock_loss_cnt;

    reset_sequencer #(
        .NDOM(NDOM), .NLOCK(NLOCK), .LOCK_DEBOUNCE(8), .STAGE_DELAY(4), .LOSS_FILTER(3)
    ) dut (
        .rstclk(clk),
        .extreset(extreset),
        .locked(locked),
        .sw_reset(sw_reset),
        .rst_out(rst_out),
        .ready(ready),
        .state(state),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    // cyc numbers edges since reset release: edge 1 is the first edge with extreset low
    int cyc = 0;
    int tot = 0;
    always @(posedge clk) begin
        tot <= tot + 1;
        if (extreset) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    typedef struct {
        int         c;
        logic [2:0] r;
        logic       rdy;
        logic [1:0] st;
        logic [7:0] llc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void push(int c, logic [2:0] r, logic rdy, logic [1:0] st, int llc);
        exp_t e;
        e.c   = c;
        e.r   = r;
        e.rdy = rdy;
        e.st  = st;
        e.llc = 8'(llc);
        q.push_back(e);
    endfunction

    function automatic int sat(int v);
        return (v > 255) ? 255 : v;
    endfunction

    // full release sequence starting with RELEASE entered at edge r
    task automatic expect_seq(int r, int llc);
        push(r,      3'b111, 1'b0, 2'd2, llc);
        push(r + 4,  3'b110, 1'b0, 2'd2, llc);
        push(r + 8,  3'b100, 1'b0, 2'd2, llc);
        push(r + 12, 3'b000, 1'b1, 2'd3, llc);
    endtask

    task automatic wait_to(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // monitor
    logic        mon_first = 1'b1;
    logic [13:0] mon_prev;
    logic [13:0] mon_cur;
    exp_t        mon_e;
    initial begin
        forever begin
            @(negedge clk);
            mon_cur = {rst_out, ready, state, lock_loss_cnt};
            if (mon_first || mon_cur != mon_prev) begin
                mon_first = 1'b0;
                mon_prev  = mon_cur;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got cyc=%0d rst=%b rdy=%b st=%0d llc=%0d, required no change",
                             cyc, rst_out, ready, state, lock_loss_cnt);
                end else begin
                    mon_e = q.pop_front();
                    if (mon_e.c != cyc || mon_e.r !== rst_out || mon_e.rdy !== ready ||
                        mon_e.st !== state || mon_e.llc !== lock_loss_cnt) begin
                        errors++;
                        $display("FAIL seq_step: got cyc=%0d rst=%b rdy=%b st=%0d llc=%0d, required cyc=%0d rst=%b rdy=%b st=%0d llc=%0d",
                                 cyc, rst_out, ready, state, lock_loss_cnt,
                                 mon_e.c, mon_e.r, mon_e.rdy, mon_e.st, mon_e.llc);
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        if (tot > 20000) begin
            errors++;
            $display("FAIL watchdog: got %0d edges, required under 20000", tot);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $fatal(1, "watchdog expired");
        end
    end

    int t, r, r2, k;

    initial begin
        // power-up
        push(0, 3'b111, 1'b0, 2'd0, 0);
        tick(3);
        extreset = 1'b0;
        push(1, 3'b111, 1'b0, 2'd1, 0);
        expect_seq(10, 0);
        wait_to(25);

        // 2-cycle glitch in RUN is filtered out
        locked = 2'b00;
        wait_to(27);
        locked = 2'b11;

        // 3-cycle loss in RUN restarts and counts
        wait_to(35);
        t = cyc;
        locked = 2'b00;
        push(t + 5, 3'b111, 1'b0, 2'd1, 1);
        wait_to(t + 3);
        locked = 2'b11;
        expect_seq(t + 13, 1);
        wait_to(t + 27);

        // sw_reset held, then a one-cycle locked[1] drop during debounce
        t = cyc;
        sw_reset = 1'b1;
        push(t + 1, 3'b111, 1'b0, 2'd1, 1);
        wait_to(t + 20);
        sw_reset = 1'b0;
        wait_to(t + 23);
        locked = 2'b01;
        wait_to(t + 24);
        locked = 2'b11;
        expect_seq(t + 34, 1);
        wait_to(t + 48);

        // sw_reset in RELEASE after domain 0 released
        t = cyc;
        sw_reset = 1'b1;
        push(t + 1, 3'b111, 1'b0, 2'd1, 1);
        wait_to(t + 1);
        sw_reset = 1'b0;
        r = t + 9;
        push(r,     3'b111, 1'b0, 2'd2, 1);
        push(r + 4, 3'b110, 1'b0, 2'd2, 1);
        wait_to(r + 5);
        sw_reset = 1'b1;
        push(r + 6, 3'b111, 1'b0, 2'd1, 1);
        wait_to(r + 6);
        sw_reset = 1'b0;

        // sw_reset coinciding with the third lost cycle: count unchanged
        r2 = r + 14;
        push(r2,     3'b111, 1'b0, 2'd2, 1);
        push(r2 + 4, 3'b110, 1'b0, 2'd2, 1);
        push(r2 + 5, 3'b111, 1'b0, 2'd1, 1);
        wait_to(r2);
        locked = 2'b00;
        wait_to(r2 + 3);
        locked = 2'b11;
        wait_to(r2 + 4);
        sw_reset = 1'b1;
        wait_to(r2 + 5);
        sw_reset = 1'b0;
        expect_seq(r2 + 13, 1);
        wait_to(r2 + 27);

        // 260 loss events, each caught just after RELEASE entry
        t = cyc;
        for (int n = 0; n < 260; n++) begin
            k = t + 11 * n;
            wait_to(k);
            locked = 2'b00;
            push(k + 5,  3'b111, 1'b0, 2'd1, sat(n + 2));
            push(k + 13, 3'b111, 1'b0, 2'd2, sat(n + 2));
            if (n == 259) push(k + 17, 3'b110, 1'b0, 2'd2, 255);
            wait_to(k + 3);
            locked = 2'b11;
        end

        // extreset mid-RELEASE acts without a clock edge
        wait_to(k + 18);
        push(k + 18, 3'b111, 1'b0, 2'd0, 0);
        extreset = 1'b1;
        #1;
        checks++;
        if (rst_out !== 3'b111 || ready !== 1'b0 || state !== 2'd0 || lock_loss_cnt !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: got rst=%b rdy=%b st=%0d llc=%0d, required rst=111 rdy=0 st=0 llc=0",
                     rst_out, ready, state, lock_loss_cnt);
        end
        tick(2);
        extreset = 1'b0;
        push(1, 3'b111, 1'b0, 2'd1, 0);
        expect_seq(10, 0);
        wait_to(25);
        tick(2);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_expect: got %0d unmatched entries, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
